ctrl_pipe: RTL and testbench

Parametrised, registered successor to the combinational instruction decoder. Accepts machine code over a valid/ready handshake and produces decoded control fields one cycle later. Only decoded instructions drive strobes; empty slots (bubbles) never do. Sequences multi-cycle loads, latches a sticky halt on the done instruction, and counts retired instructions. Sits between instruction ROM/fetch and the register file, ALU and data memory.

---
 rtl/ctrl_pipe_if.sv | 48 ++++
 rtl/ctrl_pipe.sv | 150 +++++++++++++++
 tb/tb_ctrl_pipe.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_if.sv
// Handshake and decoded-control bundle for ctrl_pipe.
// The illegal flag exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface ctrl_pipe_if #(
  parameter int unsigned IW   = 9,
  parameter int unsigned OPW  = 3,
  parameter int unsigned RW   = 2,
  parameter int unsigned JW   = 6,
  parameter int unsigned CNTW = 16
);
  logic            inst_valid;
  logic            inst_ready;
  logic [IW-1:0]   mach_code;
  logic            dec_ready;
  logic            dec_valid;
  logic [OPW-1:0]  Aluop;
  logic [RW-1:0]   Ra;
  logic [RW-1:0]   Rb;
  logic [RW-1:0]   Wd;
  logic [JW-1:0]   Jptr;
  logic            WenR;
  logic            WenD;
  logic            Ldr;
  logic            Str;
  logic            Done;
  logic            Busy;
  logic [CNTW-1:0] inst_count;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic            illegal;
`endif

  modport master (
    output inst_valid, mach_code, dec_ready,
    input  inst_ready, dec_valid, Aluop, Ra, Rb, Wd, Jptr, WenR, WenD, Ldr, Str, Done, Busy,
           inst_count
`ifdef CTRL_ILLEGAL_TRAP_EN
    , input illegal
`endif
  );

  modport slave (
    input  inst_valid, mach_code, dec_ready,
    output inst_ready, dec_valid, Aluop, Ra, Rb, Wd, Jptr, WenR, WenD, Ldr, Str, Done, Busy,
           inst_count
`ifdef CTRL_ILLEGAL_TRAP_EN
    , output illegal
`endif
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Registered instruction decoder: one-slot decode pipe, load-latency stall, sticky halt, retire count.
// Define CTRL_ILLEGAL_TRAP_EN to halt and flag on top-bits 3'b111 non-done words.
module ctrl_pipe #(
  parameter int unsigned   IW        = 9,
  parameter int unsigned   OPW       = 3,
  parameter int unsigned   RW        = 2,
  parameter int unsigned   JW        = 6,
  parameter int unsigned   LD_LAT    = 2,
  parameter int unsigned   CNTW      = 16,
  parameter logic [IW-1:0] DONE_CODE = 9'b011111111
) (
  input logic        Clk,
  input logic        Reset,
  ctrl_pipe_if.slave bus
);
  typedef enum logic [1:0] {StRun, StLoadWait, StHalt} state_e;

  state_e          state_q, state_d;
  logic [3:0]      lat_q, lat_d;

  logic [IW-1:0]   code;
  logic            accept;
  logic            is_str, is_done, is_halt, is_ld, is_wenr;

  logic            dec_valid_q;
  logic [OPW-1:0]  aluop_q;
  logic [RW-1:0]   ra_q, rb_q;
  logic [JW-1:0]   jptr_q;
  logic            wenr_q, wend_q, ldr_q, str_q;
  logic [CNTW-1:0] cnt_q;

  assign code    = bus.mach_code;
  assign accept  = bus.inst_valid && bus.inst_ready;
  assign is_str  = (code[IW-1 -: 3] == 3'b110);
  assign is_done = (code == DONE_CODE);

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic is_ill, illegal_q;
  assign is_ill  = (code[IW-1 -: 3] == 3'b111) && !is_done;
  assign is_halt = is_done || is_ill;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      illegal_q <= 1'b0;
    end else if (accept && is_ill) begin
      illegal_q <= 1'b1;
    end
  end

  assign bus.illegal = illegal_q;
`else
  assign is_halt = is_done;
`endif

  // Halting words never strobe, even if their opcode bits look like a load/write.
  assign is_ld   = code[IW-2] && !is_str && !is_halt;
  assign is_wenr = code[IW-3] && !is_str && !is_halt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StRun;
      lat_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      StRun: begin
        if (accept) begin
          if (is_halt) begin
            state_d = StHalt;
          end else if (is_ld) begin
            state_d = StLoadWait;
            lat_d   = 4'(LD_LAT);
          end
        end
      end
      // Leaving on 1 keeps inst_ready low for exactly LD_LAT cycles.
      StLoadWait: begin
        if (lat_q == 4'd1) begin
          state_d = StRun;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    bus.inst_ready = (state_q == StRun) && (!dec_valid_q || bus.dec_ready);
    bus.Busy       = (state_q == StLoadWait);
    bus.Done       = (state_q == StHalt);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dec_valid_q <= 1'b0;
      aluop_q     <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      jptr_q      <= '0;
      wenr_q      <= 1'b0;
      wend_q      <= 1'b0;
      ldr_q       <= 1'b0;
      str_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        dec_valid_q <= 1'b1;
        aluop_q     <= code[IW-2 -: OPW];
        ra_q        <= code[IW-2-OPW -: RW];
        rb_q        <= code[IW-2-OPW-RW -: RW];
        jptr_q      <= code[JW-1:0];
        wenr_q      <= is_wenr;
        wend_q      <= is_str;
        ldr_q       <= is_ld;
        str_q       <= is_str;
      end else if (dec_valid_q && bus.dec_ready) begin
        // Bubble: strobes drop, fields keep their last values.
        dec_valid_q <= 1'b0;
        wenr_q      <= 1'b0;
        wend_q      <= 1'b0;
        ldr_q       <= 1'b0;
        str_q       <= 1'b0;
      end
      if (accept && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

  assign bus.dec_valid  = dec_valid_q;
  assign bus.Aluop      = aluop_q;
  assign bus.Ra         = ra_q;
  assign bus.Rb         = rb_q;
  assign bus.Wd         = ra_q;
  assign bus.Jptr       = jptr_q;
  assign bus.WenR       = wenr_q;
  assign bus.WenD       = wend_q;
  assign bus.Ldr        = ldr_q;
  assign bus.Str        = str_q;
  assign bus.inst_count = cnt_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: decode table, hand-written corner sequences,
// and randomized traffic against a behavioural model.
module tb_ctrl_pipe;
  localparam logic [8:0] DONE   = 9'b011111111;
  localparam logic [8:0] LOAD   = 9'b010000000;
  localparam logic [8:0] STORE  = 9'b110100100;
  localparam logic [8:0] ALU    = 9'b001011000;
  localparam logic [8:0] NOP    = 9'b000000010;
  localparam int         LD_LAT = 2;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  ctrl_pipe_if bus ();
  ctrl_pipe_if #(.CNTW(2)) bus2 ();

  ctrl_pipe dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  ctrl_pipe #(.CNTW(2)) dut2 (.Clk(Clk), .Reset(Reset), .bus(bus2));

  // The narrow-counter instance sees exactly the same traffic.
  assign bus2.inst_valid = bus.inst_valid;
  assign bus2.mach_code  = bus.mach_code;
  assign bus2.dec_ready  = bus.dec_ready;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Behavioural model state.
  bit m_valid, m_wenr, m_wend, m_ldr, m_str, m_halt, m_ill;
  int m_aluop, m_ra, m_rb, m_jptr, m_stall, m_cnt;

  typedef struct {
    logic [8:0] code;
    logic [2:0] aluop;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [5:0] jptr;
    logic       wenr, wend, ldr, str, done;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready(input logic r);
    return !m_halt && (m_stall == 0) && (!m_valid || r);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wenr = 0; m_wend = 0; m_ldr = 0; m_str = 0; m_halt = 0; m_ill = 0;
    m_aluop = 0; m_ra = 0; m_rb = 0; m_jptr = 0; m_stall = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit acc, input logic [8:0] c, input logic r);
    int ci, top3;
    bit dn, ill, hlt;
    if (m_stall > 0) m_stall--;
    if (acc) begin
      ci   = int'(c);
      top3 = ci >> 6;
      dn   = (ci == 255);
      ill  = 0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ill  = (top3 == 7) && !dn;
`endif
      hlt     = dn || ill;
      m_valid = 1;
      m_aluop = (ci >> 5) & 7;
      m_ra    = (ci >> 3) & 3;
      m_rb    = (ci >> 1) & 3;
      m_jptr  = ci & 63;
      m_str   = (top3 == 6);
      m_wend  = m_str;
      m_ldr   = (((ci >> 7) & 1) == 1) && !m_str && !hlt;
      m_wenr  = (((ci >> 6) & 1) == 1) && !m_str && !hlt;
      if (hlt) m_halt = 1;
      if (ill) m_ill = 1;
      if (m_ldr) m_stall = LD_LAT;
      if (m_cnt < 65535) m_cnt++;
    end else if (m_valid && r) begin
      m_valid = 0; m_wenr = 0; m_wend = 0; m_ldr = 0; m_str = 0;
    end
  endtask

  task automatic compare_all();
    chk("dec_valid", 32'(bus.dec_valid), 32'(m_valid));
    chk("Aluop", 32'(bus.Aluop), 32'(m_aluop));
    chk("Ra", 32'(bus.Ra), 32'(m_ra));
    chk("Rb", 32'(bus.Rb), 32'(m_rb));
    chk("Wd", 32'(bus.Wd), 32'(m_ra));
    chk("Jptr", 32'(bus.Jptr), 32'(m_jptr));
    chk("WenR", 32'(bus.WenR), 32'(m_wenr));
    chk("WenD", 32'(bus.WenD), 32'(m_wend));
    chk("Ldr", 32'(bus.Ldr), 32'(m_ldr));
    chk("Str", 32'(bus.Str), 32'(m_str));
    chk("Done", 32'(bus.Done), 32'(m_halt));
    chk("Busy", 32'(bus.Busy), 32'(m_stall > 0));
    chk("inst_count", 32'(bus.inst_count), 32'(m_cnt));
    chk("inst_count_sat", 32'(bus2.inst_count), 32'((m_cnt > 3) ? 3 : m_cnt));
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("illegal", 32'(bus.illegal), 32'(m_ill));
`endif
  endtask

  // Called at a falling edge; checks outputs before any rising edge.
  task automatic do_reset();
    Reset = 1'b1;
    bus.inst_valid = 1'b0;
    bus.mach_code  = '0;
    bus.dec_ready  = 1'b0;
    model_reset();
    #1;
    compare_all();
    #1;
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic step(input logic v, input logic [8:0] c, input logic r);
    bit acc;
    bus.inst_valid = v;
    bus.mach_code  = c;
    bus.dec_ready  = r;
    #1;
    chk("inst_ready", 32'(bus.inst_ready), 32'(m_ready(r)));
    acc = v && m_ready(r);
    @(posedge Clk);
    model_edge(acc, c, r);
    #1;
    compare_all();
    @(negedge Clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] snap;
    int          zeros;
    logic        v, r;
    logic [8:0]  c;
    checks = 0;
    errors = 0;

    tbl[0] = '{ALU,   3'b010, 2'b11, 2'b00, 6'b011000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{LOAD,  3'b100, 2'b00, 2'b00, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{STORE, 3'b101, 2'b00, 2'b10, 6'b100100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{DONE,  3'b111, 2'b11, 2'b11, 6'b111111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{9'b101110101, 3'b011, 2'b10, 2'b10, 6'b110101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef CTRL_ILLEGAL_TRAP_EN
    tbl[5] = '{9'b111000000, 3'b110, 2'b00, 2'b00, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    tbl[5] = '{9'b111000000, 3'b110, 2'b00, 2'b00, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`endif

    do_reset();
    chk("reset_count", 32'(bus.inst_count), 32'd0);
    chk("reset_ready", 32'(bus.inst_ready), 32'd1);

    // Decode table: one slot each, then a bubble that keeps fields but drops strobes.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      step(1'b1, tbl[i].code, 1'b1);
      chk("tbl_Aluop", 32'(bus.Aluop), 32'(tbl[i].aluop));
      chk("tbl_Ra", 32'(bus.Ra), 32'(tbl[i].ra));
      chk("tbl_Rb", 32'(bus.Rb), 32'(tbl[i].rb));
      chk("tbl_Jptr", 32'(bus.Jptr), 32'(tbl[i].jptr));
      chk("tbl_strobes", 32'({bus.WenR, bus.WenD, bus.Ldr, bus.Str}),
          32'({tbl[i].wenr, tbl[i].wend, tbl[i].ldr, tbl[i].str}));
      chk("tbl_Done", 32'(bus.Done), 32'(tbl[i].done));
      step(1'b0, 9'd0, 1'b1);
      chk("bubble_strobes", 32'({bus.dec_valid, bus.WenR, bus.WenD, bus.Ldr, bus.Str}), 32'd0);
      chk("bubble_hold", 32'(bus.Aluop), 32'(tbl[i].aluop));
    end

    // Asynchronous reset out of HALT, then out of LOAD_WAIT.
    do_reset();
    step(1'b1, DONE, 1'b1);
    step(1'b0, 9'd0, 1'b1);
    chk("pre_rst_done", 32'(bus.Done), 32'd1);
    do_reset();
    chk("rst_halt_done", 32'(bus.Done), 32'd0);
    step(1'b1, LOAD, 1'b0);
    chk("pre_rst_busy", 32'(bus.Busy), 32'd1);
    do_reset();
    chk("rst_load", 32'({bus.Busy, bus.Ldr, bus.dec_valid, bus.Done}), 32'd0);
    chk("rst_load_count", 32'(bus.inst_count), 32'd0);

    // Load with inst_valid held: two stalled cycles, accept on the third.
    do_reset();
    step(1'b1, LOAD, 1'b1);
    chk("ld_Ldr", 32'(bus.Ldr), 32'd1);
    chk("ld_Busy", 32'(bus.Busy), 32'd1);
    zeros = 0;
    for (int k = 0; k < 3; k++) begin
      bus.inst_valid = 1'b1;
      bus.mach_code  = ALU;
      bus.dec_ready  = 1'b1;
      #1;
      if (k < 2) begin
        if (!bus.inst_ready) zeros++;
      end else begin
        chk("ld_resume", 32'(bus.inst_ready), 32'd1);
      end
      step(1'b1, ALU, 1'b1);
    end
    chk("ld_stall_cycles", 32'(zeros), 32'd2);
    chk("ld_count", 32'(bus.inst_count), 32'd2);

    // Store under backpressure: everything frozen for three cycles, drains on the fourth.
    do_reset();
    step(1'b1, STORE, 1'b0);
    snap = {bus.Aluop, bus.Ra, bus.Rb, bus.Jptr, bus.Str, bus.WenD, bus.dec_valid};
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 9'd0, 1'b0);
      chk("st_hold", 32'({bus.Aluop, bus.Ra, bus.Rb, bus.Jptr, bus.Str, bus.WenD, bus.dec_valid}),
          32'(snap));
      chk("st_Str", 32'(bus.Str), 32'd1);
    end
    step(1'b0, 9'd0, 1'b1);
    chk("st_drain", 32'({bus.Str, bus.WenD, bus.dec_valid}), 32'd0);

    // Done: sticky halt, no strobes, counted once.
    do_reset();
    step(1'b1, DONE, 1'b1);
    chk("done_set", 32'(bus.Done), 32'd1);
    chk("done_strobes", 32'({bus.WenR, bus.WenD, bus.Ldr, bus.Str}), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, ALU, 1'b1);
      chk("done_ready", 32'(bus.inst_ready), 32'd0);
    end
    chk("done_count", 32'(bus.inst_count), 32'd1);

    // Two-bit counter saturates at 3.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, NOP, 1'b1);
    chk("sat5", 32'(bus2.inst_count), 32'd3);
    step(1'b1, NOP, 1'b1);
    step(1'b0, 9'd0, 1'b1);
    chk("sat_hold", 32'(bus2.inst_count), 32'd3);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ((i % 500 == 0) || (m_halt && ($urandom_range(0, 7) == 0))) do_reset();
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      c = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 63) == 0) c = DONE;
      step(v, c, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
